cnt_seq_checker: RTL and testbench
==================================

// Module: cnt_seq_checker
// PURPOSE
//  Receive-side checker for the mod-100 counter stream (o_cnt of counter_100).
//  Samples the count each valid cycle, predicts the next value, and locks after
//  LOCK_CNT consecutive correct steps. Flags mismatches, counts errors and wraps.
//  Sits next to counter_100 in the same clock domain, as an in-system monitor.
// PARAMETERS
//  CNT_MAX   99  last count value before wrap to 0
//  CNT_W     7   width of the sampled count
//  LOCK_CNT  4   consecutive correct steps required for lock (1..15)
//  ERR_W     8   width of the error counter (saturating)
//  WRAP_W    16  width of the wrap counter (free-running, wraps)
// PORTS
//  clk           in   1       rising-edge clock
//  reset         in   1       synchronous, active-high reset
//  i_valid       in   1       i_cnt is valid this cycle
//  i_cnt         in   CNT_W   count value under check
//  o_locked      out  1       checker is in LOCKED
//  o_err_pulse   out  1       1-cycle pulse: mismatch or out-of-range sample
//  o_err_cnt     out  ERR_W   total errors, saturates at all-ones
//  o_wrap_pulse  out  1       1-cycle pulse: CNT_MAX->0 step seen while LOCKED
//  o_wrap_cnt    out  WRAP_W  wraps seen while LOCKED, modulo 2^WRAP_W
// BEHAVIOUR
//  - Reset (sync, high): state=IDLE, prev=0, run=0; all outputs 0.
//  - Only cycles with i_valid=1 are processed; i_valid=0 holds all state,
//    pulses are 0. Gaps in i_valid are not errors.
//  - exp = (prev==CNT_MAX) ? 0 : prev+1 (CNT_W-bit arithmetic).
//  - bad = (i_cnt > CNT_MAX). ok = !bad && (i_cnt == exp).
//  - FSM, evaluated on valid cycles:
//    IDLE  : bad -> stay, err; else prev<=i_cnt, run<=0, ->ACQ. No compare.
//    ACQ   : ok  -> run<=run+1; run+1==LOCK_CNT -> LOCKED.
//            !ok -> run<=0, stay ACQ; err only if bad. prev<=i_cnt unless bad.
//    LOCKED: ok  -> stay; if prev==CNT_MAX wrap pulse, o_wrap_cnt+1.
//            !ok -> err, run<=0, ->ACQ; prev<=i_cnt unless bad (then ->IDLE).
//  - Mismatches in ACQ are resynchronisation, not errors; only out-of-range
//    values count as errors outside LOCKED.
//  - Latency: all outputs registered; result appears 1 clk after the valid
//    sample. o_locked rises the cycle after the LOCK_CNT-th correct step.
//  - o_err_cnt saturates at 2^ERR_W-1; further errors still pulse.
//  - Reset mid-stream wins over any valid sample in the same cycle.
// CONFIGURATION
//  CNT_CHK_STICKY_EN defined: extra port o_err_sticky (out, 1): set on any
//    error pulse, cleared only by reset; also blocks re-entry to LOCKED
//    (ACQ never advances to LOCKED while sticky=1).
//  Not defined: port absent; relock after an error is normal.
// STRUCTURE
//  Shared package cnt_pkg: state enum (IDLE/ACQ/LOCKED, 2 bits),
//    CNT100_MAX=99, CNT100_W=7 constants shared with counter_100.
//  One sub-module: sat_counter (width param, inc, saturating) for o_err_cnt.
//  FSM, predictor and wrap counter stay in this module.
// TESTING
//  T1 reset 2 clk, then drive counter_100 o_cnt with i_valid=1 -> o_locked=1
//     after 5th sample (4 steps); o_err_cnt=0 over 300 cycles.
//  T2 locked, sequence ..98,99,0,1 -> o_wrap_pulse once 1 clk after 0 sample;
//     o_wrap_cnt=1 after first wrap, 2 after second.
//  T3 locked at 40, inject 45 -> o_err_pulse 1 clk, o_err_cnt=1, o_locked=0;
//     then 46,47,48,49 -> relocked.
//  T4 inject i_cnt=120 in each state -> err pulse; LOCKED->IDLE; ERR_W=2,
//     5 errors -> o_err_cnt stays 3.
//  T5 locked, i_valid low 10 cycles, resume with exp value -> no error, locked;
//     reset asserted mid-stream -> all outputs 0 next clk, state IDLE.
//  T6 CNT_CHK_STICKY_EN: error at T3 -> o_err_sticky=1, o_locked stays 0
//     for 50 correct samples; reset clears both.

Source files
------------

// File: rtl/cnt_pkg.sv
// Constants and types shared by counter_100 and its receive-side checker.
package cnt_pkg;

    localparam int CNT100_MAX = 99;
    localparam int CNT100_W   = 7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACQ    = 2'd1,
        ST_LOCKED = 2'd2
    } chk_state_t;

endpackage

// File: rtl/cnt_seq_checker_if.sv
// Sample stream and status bundle of cnt_seq_checker.
// o_err_sticky is present only when CNT_CHK_STICKY_EN is defined.
interface cnt_seq_checker_if #(
    parameter int CNT_W  = 7,
    parameter int ERR_W  = 8,
    parameter int WRAP_W = 16
);
    logic              i_valid;
    logic [CNT_W-1:0]  i_cnt;
    logic              o_locked;
    logic              o_err_pulse;
    logic [ERR_W-1:0]  o_err_cnt;
    logic              o_wrap_pulse;
    logic [WRAP_W-1:0] o_wrap_cnt;
`ifdef CNT_CHK_STICKY_EN
    logic              o_err_sticky;
`endif

    modport master (
        output i_valid, i_cnt,
`ifdef CNT_CHK_STICKY_EN
        input  o_err_sticky,
`endif
        input  o_locked, o_err_pulse, o_err_cnt, o_wrap_pulse, o_wrap_cnt
    );

    modport slave (
        input  i_valid, i_cnt,
`ifdef CNT_CHK_STICKY_EN
        output o_err_sticky,
`endif
        output o_locked, o_err_pulse, o_err_cnt, o_wrap_pulse, o_wrap_cnt
    );
endinterface

// File: rtl/cnt_seq_checker_sat_counter.sv
// Saturating up-counter: holds at all-ones once reached.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt
);
    logic [WIDTH-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg <= '0;
        end else if (inc && (cnt_reg != '1)) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign cnt = cnt_reg;
endmodule

// File: rtl/cnt_seq_checker.sv
// In-system monitor for the mod-100 counter stream: predicts, locks, counts errors/wraps.
// Optional CNT_CHK_STICKY_EN adds o_err_sticky and blocks relock after any error.
module cnt_seq_checker
    import cnt_pkg::*;
#(
    parameter int CNT_MAX  = CNT100_MAX,
    parameter int CNT_W    = CNT100_W,
    parameter int LOCK_CNT = 4,
    parameter int ERR_W    = 8,
    parameter int WRAP_W   = 16
) (
    input logic              clk,
    input logic              reset,
    cnt_seq_checker_if.slave bus
);
    localparam int RUN_W = 4;

    chk_state_t        state_reg;
    logic [CNT_W-1:0]  prev_reg;
    logic [RUN_W-1:0]  run_reg;
    logic              locked_reg;
    logic              err_pulse_reg;
    logic              wrap_pulse_reg;
    logic [WRAP_W-1:0] wrap_cnt_reg;
    logic              sticky_reg;

    logic [CNT_W-1:0]  exp_cnt;
    logic [RUN_W-1:0]  run_next;
    logic              bad;
    logic              ok;
    logic              err_now;
    logic [ERR_W-1:0]  err_cnt;

    always_comb begin
        exp_cnt  = (prev_reg == CNT_W'(CNT_MAX)) ? '0 : prev_reg + 1'b1;
        bad      = bus.i_cnt > CNT_W'(CNT_MAX);
        ok       = !bad && (bus.i_cnt == exp_cnt);
        run_next = run_reg + 1'b1;
        // Out-of-range is always an error; a mismatch only counts once locked.
        err_now  = bus.i_valid && (bad || ((state_reg == ST_LOCKED) && !ok));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            prev_reg       <= '0;
            run_reg        <= '0;
            locked_reg     <= 1'b0;
            err_pulse_reg  <= 1'b0;
            wrap_pulse_reg <= 1'b0;
            wrap_cnt_reg   <= '0;
        end else begin
            err_pulse_reg  <= err_now;
            wrap_pulse_reg <= 1'b0;
            if (bus.i_valid) begin
                case (state_reg)
                    ST_IDLE: begin
                        if (!bad) begin
                            prev_reg  <= bus.i_cnt;
                            run_reg   <= '0;
                            state_reg <= ST_ACQ;
                        end
                    end
                    ST_ACQ: begin
                        if (ok) begin
                            prev_reg <= bus.i_cnt;
                            run_reg  <= run_next;
                            if ((run_next == RUN_W'(LOCK_CNT)) && !sticky_reg) begin
                                state_reg  <= ST_LOCKED;
                                locked_reg <= 1'b1;
                            end
                        end else begin
                            run_reg <= '0;
                            if (!bad) prev_reg <= bus.i_cnt;
                        end
                    end
                    ST_LOCKED: begin
                        if (ok) begin
                            prev_reg <= bus.i_cnt;
                            if (prev_reg == CNT_W'(CNT_MAX)) begin
                                wrap_pulse_reg <= 1'b1;
                                wrap_cnt_reg   <= wrap_cnt_reg + 1'b1;
                            end
                        end else begin
                            run_reg    <= '0;
                            locked_reg <= 1'b0;
                            if (bad) begin
                                state_reg <= ST_IDLE;
                            end else begin
                                prev_reg  <= bus.i_cnt;
                                state_reg <= ST_ACQ;
                            end
                        end
                    end
                    default: begin
                        state_reg  <= ST_IDLE;
                        locked_reg <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef CNT_CHK_STICKY_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            sticky_reg <= 1'b0;
        end else if (err_now) begin
            sticky_reg <= 1'b1;
        end
    end
    assign bus.o_err_sticky = sticky_reg;
`else
    assign sticky_reg = 1'b0;
`endif

    sat_counter #(.WIDTH(ERR_W)) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (err_now),
        .cnt   (err_cnt)
    );

    assign bus.o_locked     = locked_reg;
    assign bus.o_err_pulse  = err_pulse_reg;
    assign bus.o_err_cnt    = err_cnt;
    assign bus.o_wrap_pulse = wrap_pulse_reg;
    assign bus.o_wrap_cnt   = wrap_cnt_reg;
endmodule

// File: tb/tb_cnt_seq_checker.sv
// Randomised and directed bench for cnt_seq_checker against a rule-level model.
// Two instances share the stimulus: default ERR_W and ERR_W=2 for saturation.
module tb_cnt_seq_checker;
    localparam int LOCK = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cnt_seq_checker_if #(.CNT_W(7), .ERR_W(8), .WRAP_W(16)) bus ();
    cnt_seq_checker_if #(.CNT_W(7), .ERR_W(2), .WRAP_W(16)) bus_s ();

    cnt_seq_checker #(.LOCK_CNT(LOCK), .ERR_W(8)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    cnt_seq_checker #(.LOCK_CNT(LOCK), .ERR_W(2)) dut_s (
        .clk(clk), .reset(reset), .bus(bus_s)
    );

    int total = 0;
    int bad = 0;
    bit cmp_en = 1'b0;

    // Model: whether a reference value exists, whether locked, streak length.
    bit m_have_ref, m_locked, m_sticky, m_err_pulse, m_wrap_pulse;
    int m_prev, m_run, m_err, m_wrap;

    task automatic chk(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s act=%0d req=%0d t=%0t", name, act, req, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit v, input int c);
        bit is_bad, is_ok;
        m_err_pulse  = 1'b0;
        m_wrap_pulse = 1'b0;
        if (r) begin
            m_have_ref = 0; m_locked = 0; m_sticky = 0;
            m_prev = 0; m_run = 0; m_err = 0; m_wrap = 0;
            return;
        end
        if (!v) return;
        is_bad = c > 99;
        is_ok  = !is_bad && (c == (m_prev + 1) % 100);
        if (is_bad || (m_locked && !is_ok)) begin
            m_err_pulse = 1'b1;
            m_err++;
`ifdef CNT_CHK_STICKY_EN
            m_sticky = 1'b1;
`endif
        end
        if (!m_have_ref) begin
            if (!is_bad) begin m_have_ref = 1; m_prev = c; m_run = 0; end
        end else if (m_locked) begin
            if (is_ok) begin
                if (m_prev == 99) begin m_wrap_pulse = 1'b1; m_wrap++; end
                m_prev = c;
            end else begin
                m_locked = 0; m_run = 0;
                if (is_bad) m_have_ref = 0; else m_prev = c;
            end
        end else begin
            if (is_ok) begin
                m_run++; m_prev = c;
                if (m_run >= LOCK && !m_sticky) m_locked = 1;
            end else begin
                m_run = 0;
                if (!is_bad) m_prev = c;
            end
        end
    endtask

    task automatic step(input bit r, input bit v, input int c);
        @(negedge clk);
        reset = r;
        bus.i_valid = v;   bus.i_cnt = 7'(c);
        bus_s.i_valid = v; bus_s.i_cnt = 7'(c);
        @(posedge clk);
        model_step(r, v, c);
        cmp_en = 1'b1;
        #3;
    endtask

    always @(posedge clk) begin
        #2;
        if (cmp_en) begin
            chk("locked", bus.o_locked, m_locked);
            chk("err_pulse", bus.o_err_pulse, m_err_pulse);
            chk("err_cnt", bus.o_err_cnt, (m_err > 255) ? 255 : m_err);
            chk("wrap_pulse", bus.o_wrap_pulse, m_wrap_pulse);
            chk("wrap_cnt", bus.o_wrap_cnt, m_wrap % 65536);
            chk("err_cnt_sat2", bus_s.o_err_cnt, (m_err > 3) ? 3 : m_err);
            chk("locked_s", bus_s.o_locked, m_locked);
`ifdef CNT_CHK_STICKY_EN
            chk("sticky", bus.o_err_sticky, m_sticky);
`endif
        end
    end

    initial begin
        int s;
        bit r, v;
        int c, p;
        reset = 1'b1;
        bus.i_valid = 1'b0;   bus.i_cnt = '0;
        bus_s.i_valid = 1'b0; bus_s.i_cnt = '0;

        // T1: two reset clocks, then a clean stream for 300 cycles.
        step(1, 0, 0);
        step(1, 0, 0);
        chk("rst_locked", bus.o_locked, 0);
        chk("rst_err_cnt", bus.o_err_cnt, 0);
        chk("rst_wrap_cnt", bus.o_wrap_cnt, 0);
        for (int i = 0; i < 300; i++) begin
            step(0, 1, i % 100);
            if (i == 3) chk("t1_not_locked_4th", bus.o_locked, 0);
            if (i == 4) chk("t1_locked_5th", bus.o_locked, 1);
            if (i == 100) chk("t2_wrap_pulse", bus.o_wrap_pulse, 1);
            if (i == 101) chk("t2_wrap_cnt1", bus.o_wrap_cnt, 1);
        end
        chk("t1_err_cnt", bus.o_err_cnt, 0);
        chk("t2_wrap_cnt2", bus.o_wrap_cnt, 2);

        // T3: locked at 40, inject 45, then resync on 46..49.
        step(1, 0, 0);
        for (int i = 36; i <= 40; i++) step(0, 1, i);
        chk("t3_locked_40", bus.o_locked, 1);
        step(0, 1, 45);
        chk("t3_err_pulse", bus.o_err_pulse, 1);
        chk("t3_err_cnt", bus.o_err_cnt, 1);
        chk("t3_unlocked", bus.o_locked, 0);
        for (int i = 46; i <= 49; i++) step(0, 1, i);
`ifdef CNT_CHK_STICKY_EN
        chk("t6_no_relock", bus.o_locked, 0);
        for (int i = 50; i < 100; i++) step(0, 1, i);
        chk("t6_still_unlocked", bus.o_locked, 0);
        chk("t6_sticky", bus.o_err_sticky, 1);
        step(1, 0, 0);
        chk("t6_sticky_clr", bus.o_err_sticky, 0);
`else
        chk("t3_relocked", bus.o_locked, 1);
`endif

        // T4: out-of-range sample in every state, then saturation of ERR_W=2.
        step(1, 0, 0);
        step(0, 1, 120);
        chk("t4_idle_err", bus.o_err_pulse, 1);
        step(0, 1, 5);
        step(0, 1, 120);
        chk("t4_acq_err", bus.o_err_pulse, 1);
        for (int i = 6; i <= 9; i++) step(0, 1, i);
        step(0, 1, 120);
        chk("t4_locked_err", bus.o_err_pulse, 1);
        chk("t4_locked_drop", bus.o_locked, 0);
        step(0, 1, 121);
        step(0, 1, 127);
        chk("t4_err_cnt5", bus.o_err_cnt, 5);
        chk("t4_err_sat3", bus_s.o_err_cnt, 3);

        // T5: gap in valid while locked, then reset during a valid sample.
        step(1, 0, 0);
        for (int i = 10; i <= 14; i++) step(0, 1, i);
        for (int i = 0; i < 10; i++) step(0, 0, 77);
        step(0, 1, 15);
        chk("t5_gap_locked", bus.o_locked, 1);
        chk("t5_gap_no_err", bus.o_err_cnt, 0);
        step(1, 1, 16);
        chk("t5_rst_locked", bus.o_locked, 0);

        // Randomised stream: mostly in-sequence, with jumps, bad values, gaps, resets.
        s = 0;
        for (int i = 0; i < 4000; i++) begin
            r = ($urandom_range(0, 399) == 0);
            v = ($urandom_range(0, 3) != 0);
            p = int'($urandom_range(0, 29));
            if (p == 0) begin
                c = int'($urandom_range(100, 127));
            end else if (p == 1) begin
                c = int'($urandom_range(0, 99));
                if (v) s = c;
            end else begin
                c = (s + 1) % 100;
                if (v) s = c;
            end
            step(r, v, c);
        end

        cmp_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
